// File: rtl/muldiv_unit_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: funct codes, FSM encoding, widths.
// Optional build macro MULDIV_FAST_MUL_EN selects a single-cycle multiplier (see muldiv_core).
package muldiv_unit_pkg;

    localparam int WIDTH = 32;
    localparam int ITER  = WIDTH;

    localparam logic [5:0] F_MFHI  = 6'd16;
    localparam logic [5:0] F_MTHI  = 6'd17;
    localparam logic [5:0] F_MFLO  = 6'd18;
    localparam logic [5:0] F_MTLO  = 6'd19;
    localparam logic [5:0] F_MULT  = 6'd24;
    localparam logic [5:0] F_MULTU = 6'd25;
    localparam logic [5:0] F_DIV   = 6'd26;
    localparam logic [5:0] F_DIVU  = 6'd27;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    typedef struct packed {
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] lo;
    } hilo_t;

    function automatic logic is_arith(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Controller-facing bundle of the multiply/divide unit: request, operands and read/stall results.
interface muldiv_unit_if;
    import muldiv_unit_pkg::*;

    logic             en;
    logic [5:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] rdata;
    logic             busy;
    logic             stall;

    modport master (
        output en, func, a, b,
        input  rdata, busy, stall
    );

    modport slave (
        input  en, func, a, b,
        output rdata, busy, stall
    );

endinterface

// File: rtl/muldiv_core.sv
// Iterative 32-step shift-add multiplier / restoring divider with sign fixup.
// MULDIV_FAST_MUL_EN: multiply is done in one cycle inside FIX instead of 32 MUL steps.
module muldiv_core
    import muldiv_unit_pkg::*;
(
    input  logic             clk,
    input  logic             _reset,
    input  logic             start,
    input  logic             is_div,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output hilo_t            res
);

    localparam logic [5:0] LAST_STEP = 6'(ITER - 1);
`ifdef MULDIV_FAST_MUL_EN
    localparam logic [1:0] S_MUL_ENTRY = S_FIX;
`else
    localparam logic [1:0] S_MUL_ENTRY = S_MUL;
`endif

    logic [1:0]         state_reg;
    logic [5:0]         count_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0]   operand_reg;
    logic               neg_res_reg;
    logic               neg_rem_reg;
    logic               is_div_reg;
    logic               dz_reg;
    logic               dz_wait_reg;

    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               div_zero;

    assign a_neg    = is_signed & a[WIDTH-1];
    assign b_neg    = is_signed & b[WIDTH-1];
    assign a_mag    = a_neg ? -a : a;
    assign b_mag    = b_neg ? -b : b;
    assign div_zero = is_div & (b == '0);

    // acc_reg layout: multiply {partial product, remaining multiplier bits}; divide {remainder, quotient}.
`ifndef MULDIV_FAST_MUL_EN
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_step;
    assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, operand_reg} : '0);
    assign mul_step = {mul_sum, acc_reg[WIDTH-1:1]};
`endif

    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] div_step;
    assign div_shift = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, operand_reg};
    // Bit WIDTH of the difference is set exactly when the trial subtract borrows.
    assign div_step  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                       : {div_diff[WIDTH-1:0],  acc_reg[WIDTH-2:0], 1'b1};

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_reg   <= S_IDLE;
            count_reg   <= '0;
            acc_reg     <= '0;
            operand_reg <= '0;
            neg_res_reg <= 1'b0;
            neg_rem_reg <= 1'b0;
            is_div_reg  <= 1'b0;
            dz_reg      <= 1'b0;
            dz_wait_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        count_reg   <= '0;
                        operand_reg <= b_mag;
                        neg_res_reg <= a_neg ^ b_neg;
                        neg_rem_reg <= a_neg;
                        is_div_reg  <= is_div;
                        dz_reg      <= div_zero;
                        if (div_zero) begin
                            acc_reg     <= {a, {WIDTH{1'b1}}};
                            dz_wait_reg <= 1'b1;
                            state_reg   <= S_FIX;
                        end else begin
                            acc_reg     <= {{WIDTH{1'b0}}, a_mag};
                            dz_wait_reg <= 1'b0;
                            state_reg   <= is_div ? S_DIV : S_MUL_ENTRY;
                        end
                    end
                end
`ifndef MULDIV_FAST_MUL_EN
                S_MUL: begin
                    acc_reg   <= mul_step;
                    count_reg <= count_reg + 6'd1;
                    if (count_reg == LAST_STEP) begin
                        state_reg <= S_FIX;
                    end
                end
`endif
                S_DIV: begin
                    acc_reg   <= div_step;
                    count_reg <= count_reg + 6'd1;
                    if (count_reg == LAST_STEP) begin
                        state_reg <= S_FIX;
                    end
                end
                S_FIX: begin
                    // Divide-by-zero dwells one extra cycle so its busy window is two cycles.
                    if (dz_wait_reg) begin
                        dz_wait_reg <= 1'b0;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    logic [2*WIDTH-1:0] mul_raw;
    logic [2*WIDTH-1:0] mul_fixed;
    logic [WIDTH-1:0]   quo_fixed;
    logic [WIDTH-1:0]   rem_fixed;

`ifdef MULDIV_FAST_MUL_EN
    assign mul_raw = {{WIDTH{1'b0}}, acc_reg[WIDTH-1:0]} * {{WIDTH{1'b0}}, operand_reg};
`else
    assign mul_raw = acc_reg;
`endif
    assign mul_fixed = neg_res_reg ? -mul_raw : mul_raw;
    assign quo_fixed = neg_res_reg ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
    assign rem_fixed = neg_rem_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];

    always_comb begin
        res = '0;
        if (dz_reg) begin
            res.hi = acc_reg[2*WIDTH-1:WIDTH];
            res.lo = acc_reg[WIDTH-1:0];
        end else if (is_div_reg) begin
            res.hi = rem_fixed;
            res.lo = quo_fixed;
        end else begin
            res.hi = mul_fixed[2*WIDTH-1:WIDTH];
            res.lo = mul_fixed[WIDTH-1:0];
        end
    end

    assign busy = (state_reg != S_IDLE);
    assign done = (state_reg == S_FIX) && !dz_wait_reg;

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit: owns HI/LO, decodes mt*/mf*, stalls the controller while busy.
// MULDIV_FAST_MUL_EN selects the single-cycle multiplier in muldiv_core.
module muldiv_unit
    import muldiv_unit_pkg::*;
(
    input  logic          clk,
    input  logic          _reset,
    muldiv_unit_if.slave  bus
);

    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic             core_busy;
    logic             core_done;
    hilo_t            core_res;
    logic             idle;
    logic             start;
    logic             is_div;
    logic             is_signed;

    assign idle      = !core_busy;
    assign start     = bus.en && idle && is_arith(bus.func);
    assign is_div    = (bus.func == F_DIV)  || (bus.func == F_DIVU);
    assign is_signed = (bus.func == F_MULT) || (bus.func == F_DIV);

    muldiv_core u_core (
        .clk       (clk),
        ._reset    (_reset),
        .start     (start),
        .is_div    (is_div),
        .is_signed (is_signed),
        .a         (bus.a),
        .b         (bus.b),
        .busy      (core_busy),
        .done      (core_done),
        .res       (core_res)
    );

    // mt* requests are only honoured when idle; while busy the controller re-presents them.
    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (core_done) begin
            hi_reg <= core_res.hi;
            lo_reg <= core_res.lo;
        end else if (bus.en && idle) begin
            if (bus.func == F_MTHI) begin
                hi_reg <= bus.a;
            end
            if (bus.func == F_MTLO) begin
                lo_reg <= bus.a;
            end
        end
    end

    assign bus.rdata = (bus.func == F_MFHI) ? hi_reg : lo_reg;
    assign bus.busy  = core_busy;
    assign bus.stall = bus.en & core_busy;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit; honours MULDIV_FAST_MUL_EN for multiply latency.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic clk = 1'b0;
    logic _reset;

    muldiv_unit_if bus ();

    muldiv_unit dut (
        .clk    (clk),
        ._reset (_reset),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            cycles++;
            tick();
        end
    endtask

    task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] av,
                          input logic [31:0] bv, input int exp_cyc,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int cycles;
        logic [31:0] got_hi;
        logic [31:0] got_lo;
        bus.en   = 1'b1;
        bus.func = f;
        bus.a    = av;
        bus.b    = bv;
        tick();
        bus.en = 1'b0;
        wait_idle(cycles);
        check($sformatf("%s_cycles", name), 64'(cycles), 64'(exp_cyc));
        bus.en   = 1'b1;
        bus.func = F_MFHI;
        #1;
        got_hi = bus.rdata;
        check($sformatf("%s_hi", name), got_hi, exp_hi);
        bus.func = F_MFLO;
        #1;
        got_lo = bus.rdata;
        check($sformatf("%s_lo", name), got_lo, exp_lo);
        bus.en = 1'b0;
        $display("op %s func=%0d a=%h b=%h busy_cycles=%0d hi=%h lo=%h",
                 name, f, av, bv, cycles, got_hi, got_lo);
    endtask

    initial begin
        int cycles;
        int pre;
        logic stall_ok;

        bus.en   = 1'b0;
        bus.func = '0;
        bus.a    = '0;
        bus.b    = '0;
        _reset   = 1'b0;
        #12;
        bus.func = F_MFHI;
        #1;
        check("rst_busy", bus.busy, 1'b0);
        check("rst_hi", bus.rdata, 32'h0);
        bus.func = F_MFLO;
        #1;
        check("rst_lo", bus.rdata, 32'h0);
        $display("op reset busy=%0d", bus.busy);
        _reset = 1'b1;
        tick();

        run_op("multu_max", F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001);
        run_op("mult_neg",  F_MULT,  32'hFFFFFFFD, 32'd5,        MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFF1);
        run_op("div_neg_a", F_DIV,   32'hFFFFFFF9, 32'd2,        DIV_LAT, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("div_neg_b", F_DIV,   32'd7,        32'hFFFFFFFE, DIV_LAT, 32'h00000001, 32'hFFFFFFFD);
        run_op("divu",      F_DIVU,  32'd100,      32'd7,        DIV_LAT, 32'd2,        32'd14);
        run_op("div_zero",  F_DIV,   32'h12345678, 32'h0,        2,       32'h12345678, 32'hFFFFFFFF);
        run_op("div_ovf",   F_DIV,   32'h80000000, 32'hFFFFFFFF, DIV_LAT, 32'h0,        32'h80000000);

        // mfhi presented while a multiply runs: must stall and then read the new HI.
        bus.en   = 1'b1;
        bus.func = F_MULT;
        bus.a    = 32'h00010000;
        bus.b    = 32'h00010000;
        tick();
        bus.en = 1'b0;
        pre = (MUL_LAT > 5) ? 4 : 0;
        repeat (pre) tick();
        bus.en   = 1'b1;
        bus.func = F_MFHI;
        #1;
        check("mf_stall", bus.stall, 1'b1);
        check("mf_old_hi", bus.rdata, 32'h0);
        stall_ok = 1'b1;
        cycles = 0;
        while (bus.busy && cycles < 100) begin
            if (!bus.stall) stall_ok = 1'b0;
            cycles++;
            tick();
        end
        check("mf_stall_held", stall_ok, 1'b1);
        check("mf_stall_drop", bus.stall, 1'b0);
        check("mf_new_hi", bus.rdata, 32'h00000001);
        $display("op mfhi_stall stalled_cycles=%0d rdata=%h", cycles, bus.rdata);
        bus.en = 1'b0;

        // mtlo presented while busy: ignored until the unit goes idle.
        bus.en   = 1'b1;
        bus.func = F_MULTU;
        bus.a    = 32'd3;
        bus.b    = 32'd4;
        tick();
        bus.func = F_MTLO;
        bus.a    = 32'hCAFEF00D;
        check("mt_stall", bus.stall, 1'b1);
        check("mt_lo_held", bus.rdata, 32'h0);
        wait_idle(cycles);
        check("mt_lo_product", bus.rdata, 32'd12);
        tick();
        check("mt_lo_accept", bus.rdata, 32'hCAFEF00D);
        $display("op mtlo_stall busy_cycles=%0d lo=%h", cycles, bus.rdata);
        bus.en = 1'b0;

        bus.en   = 1'b1;
        bus.func = F_MTHI;
        bus.a    = 32'hDEADBEEF;
        tick();
        bus.func = F_MFHI;
        #1;
        check("mthi_stall", bus.stall, 1'b0);
        check("mthi_rdata", bus.rdata, 32'hDEADBEEF);
        $display("op mthi_mfhi rdata=%h", bus.rdata);
        bus.en = 1'b0;
        tick();

        // Unlisted funct with en=1 must not touch state.
        bus.en   = 1'b1;
        bus.func = 6'd20;
        bus.a    = 32'h55555555;
        bus.b    = 32'd3;
        tick();
        bus.en = 1'b0;
        check("bad_func_busy", bus.busy, 1'b0);
        bus.func = F_MFHI;
        #1;
        check("bad_func_hi", bus.rdata, 32'hDEADBEEF);
        bus.func = F_MFLO;
        #1;
        check("bad_func_lo", bus.rdata, 32'hCAFEF00D);
        $display("op bad_func busy=%0d lo=%h", bus.busy, bus.rdata);

        // Asynchronous reset in the middle of a divide.
        tick();
        bus.en   = 1'b1;
        bus.func = F_DIV;
        bus.a    = 32'd1000;
        bus.b    = 32'd3;
        tick();
        bus.en = 1'b0;
        repeat (10) tick();
        check("mid_div_busy", bus.busy, 1'b1);
        #2;
        _reset   = 1'b0;
        bus.func = F_MFHI;
        #1;
        check("arst_busy", bus.busy, 1'b0);
        check("arst_hi", bus.rdata, 32'h0);
        bus.func = F_MFLO;
        #1;
        check("arst_lo", bus.rdata, 32'h0);
        $display("op async_reset busy=%0d lo=%h", bus.busy, bus.rdata);
        _reset = 1'b1;
        tick();

        run_op("divu_after_rst", F_DIVU, 32'd100, 32'd7, DIV_LAT, 32'd2, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
